// File: rtl/io_ctrl_pkg.sv
// Shared constants and the seven-segment decoder for the memory-mapped I/O controller.
//   NUM_DIGITS : anode slots scanned, including the blank slot
//   BLANK_SEG  : all segments off (active-low)
//   IO_ADDR    : data-memory word address of the I/O register (used by the memory block)
//   hex7()     : 4-bit value -> active-low segments {g,f,e,d,c,b,a}
package io_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [6:0]  BLANK_SEG  = 7'h7F;
  localparam int unsigned IO_ADDR    = 4096;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [6:0] hex7(input logic [3:0] val);
    logic [6:0] seg;
    unique case (val)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_controller_if.sv
// Memory-block side of the I/O controller.
//   iomem : 12-bit display value written by the CPU (memory block -> controller)
//   ioin  : 16-bit debounced switch levels read by the CPU (controller -> memory block)
interface io_controller_if;
  logic [11:0] iomem;
  logic [15:0] ioin;

  modport master (output iomem, input ioin);
  modport slave  (input iomem, output ioin);
endinterface

// File: rtl/io_debounce.sv
// Switch synchroniser and debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   sw_raw     : raw asynchronous switch levels
//   ioin       : debounced levels; a bit changes only after DB_SAMPLES equal samples
//                taken DEBOUNCE_DIV cycles apart
module io_debounce #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEBOUNCE_DIV = 500000,
  parameter int unsigned DB_SAMPLES   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] ioin
);

  localparam int unsigned CntW    = $clog2(DEBOUNCE_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_DIV - 1);

  logic [WIDTH-1:0]                 sw_s1_q, sw_s2_q;
  logic [CntW-1:0]                  dcnt_q, dcnt_d;
  logic [WIDTH-1:0][DB_SAMPLES-1:0] hist_q, hist_d;
  logic [WIDTH-1:0]                 ioin_q, ioin_d;
  logic                             tick;

  assign tick = (dcnt_q == CntMax);

  always_comb begin
    dcnt_d = tick ? '0 : dcnt_q + 1'b1;
    hist_d = hist_q;
    ioin_d = ioin_q;
    if (tick) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        hist_d[i] = {hist_q[i][DB_SAMPLES-2:0], sw_s2_q[i]};
        // Mixed history means the input is still bouncing: hold the last accepted level.
        if (&hist_d[i]) begin
          ioin_d[i] = 1'b1;
        end else if (~|hist_d[i]) begin
          ioin_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      dcnt_q  <= '0;
      hist_q  <= '0;
      ioin_q  <= '0;
    end else begin
      sw_s1_q <= sw_raw;
      sw_s2_q <= sw_s1_q;
      dcnt_q  <= dcnt_d;
      hist_q  <= hist_d;
      ioin_q  <= ioin_d;
    end
  end

  assign ioin = ioin_q;

endmodule

// File: rtl/io_controller.sv
// Far end of the memory-mapped I/O word: drives a 4-digit multiplexed seven-segment
// display from iomem (digits 2..0 as hex, digit 3 blank) and returns debounced switches.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : iomem in, ioin out (slave side of io_controller_if)
//   sw_raw     : raw board switches
//   seg_n      : segments {g..a}, active low
//   dp_n       : decimal point, always off
//   an_n       : digit anodes, active low
module io_controller
  import io_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned DEBOUNCE_DIV = 500000,
  parameter int unsigned DB_SAMPLES   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  io_controller_if.slave        bus,
  input  logic [15:0]           sw_raw,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [3:0]            an_n
);

  localparam int unsigned CntW    = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam digit_idx_t BlankIdx = digit_idx_t'(NUM_DIGITS - 1);

  logic [CntW-1:0] rcnt_q, rcnt_d;
  digit_idx_t      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;

  always_comb begin
    rcnt_d = rcnt_q + 1'b1;
    idx_d  = idx_q;
    if (rcnt_q == CntMax) begin
      rcnt_d = '0;
      idx_d  = idx_q + 1'b1;  // 2-bit wrap gives 3 -> 0
    end
  end

  // Outputs follow the current index/iomem one cycle later.
  always_comb begin
    an_d  = 4'hF;
    seg_d = BLANK_SEG;
    if (idx_q != BlankIdx) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex7(bus.iomem[4*idx_q +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      idx_q  <= '0;
      seg_q  <= BLANK_SEG;
      an_q   <= 4'hF;
    end else begin
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;
  assign dp_n  = 1'b1;

  io_debounce #(
    .WIDTH        (16),
    .DEBOUNCE_DIV (DEBOUNCE_DIV),
    .DB_SAMPLES   (DB_SAMPLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .ioin   (bus.ioin)
  );

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller with small dividers.
module tb_io_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sw_raw;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  io_controller_if bus ();

  io_controller #(
    .REFRESH_DIV  (4),
    .DEBOUNCE_DIV (8),
    .DB_SAMPLES   (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .sw_raw (sw_raw),
    .seg_n  (seg_n),
    .dp_n   (dp_n),
    .an_n   (an_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;  // rising edges since last reset release

  // Expected digit-slot outputs, indexed by slot 0..3, for iomem = 12'h3A5.
  logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'hF};
  logic [6:0] exp_seg [4] = '{7'h12, 7'h08, 7'h30, 7'h7F};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ioin(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 27; i++) begin
      step();
      if (bus.ioin === exp) break;
    end
    check(tag, bus.ioin, exp);
  endtask

  initial begin
    int slot;
    logic glitch;

    rst_n     = 1'b1;
    sw_raw    = '0;
    bus.iomem = 12'h3A5;
    #1 rst_n  = 1'b0;
    #1;
    // 1: reset takes effect with no clock edge
    check("rst_an",   16'(an_n),  16'hF);
    check("rst_seg",  16'(seg_n), 16'h7F);
    check("rst_dp",   16'(dp_n),  16'h1);
    check("rst_ioin", bus.ioin,   16'h0000);

    // release between edges; edge n then shows slot ((n-1)/4)%4
    step();
    rst_n = 1'b1;
    cyc   = 0;

    // 2: scan pattern for two full rounds
    for (int n = 1; n <= 32; n++) begin
      step();
      slot = ((cyc - 1) / 4) % 4;
      check($sformatf("scan_an_%0d", n), 16'(an_n), 16'(exp_an[slot]));
      check($sformatf("scan_seg_%0d", n), 16'(seg_n), 16'(exp_seg[slot]));
    end

    // 5: iomem changes at the first cycle of slot 0; next edge is still slot 0
    while ((cyc % 16) != 1) step();
    check("upd_pre_an", 16'(an_n), 16'hE);
    bus.iomem = 12'h3A6;
    #1;
    check("upd_hold_seg", 16'(seg_n), 16'h12);
    step();
    check("upd_seg", 16'(seg_n), 16'h02);
    check("upd_an",  16'(an_n),  16'hE);

    // 3: held switches propagate within the worst-case latency
    sw_raw = 16'h8001;
    wait_ioin("db_rise", 16'h8001);
    sw_raw = 16'h0000;
    wait_ioin("db_fall", 16'h0000);

    // 4: a 5-cycle pulse is shorter than one sample period
    sw_raw = 16'h0001;
    for (int i = 0; i < 5; i++) step();
    sw_raw = 16'h0000;
    glitch = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.ioin !== 16'h0000) glitch = 1'b1;
    end
    check("db_short_pulse", 16'(glitch), 16'h0);

    // 6: reset mid-slot 2 with all switches accepted
    sw_raw = 16'hFFFF;
    wait_ioin("db_all", 16'hFFFF);
    while (!((((cyc - 1) / 4) % 4 == 2) && (((cyc - 1) % 4) == 1))) step();
    check("mid_an", 16'(an_n), 16'hB);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ioin", bus.ioin,   16'h0000);
    check("mid_rst_an",   16'(an_n),  16'hF);
    check("mid_rst_seg",  16'(seg_n), 16'h7F);
    #1 rst_n = 1'b1;
    cyc = 0;
    step();
    check("restart_an",  16'(an_n),  16'hE);
    check("restart_seg", 16'(seg_n), 16'h02);
    check("restart_dp",  16'(dp_n),  16'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
